// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer
//   Reads a 3-row band at a time from an 8-bit pixel memory. Within each band
//   the pixels go out column by column, three rows per column, as an
//   AXI4-Stream to a convolution core. The frame is wrapped in markers:
//   123 before the first pixel, then 124 and 79 after the last pixel.
//
// Ports
//   m00_axis_aclk    sole clock
//   m00_axis_areset  synchronous active-high reset
//   start            one-cycle pulse, honoured only when idle
//   busy / done      frame in progress / one-cycle completion pulse
//   mem_en, mem_addr pixel read request (row*IMG_W+col), data one cycle later
//   mem_rdata        returned pixel
//   m00_axis_*       output stream (tdata zero-extended, tlast ends a band)
//   stall_cycles     only with CONV_SEQ_STATS_EN: saturating count of
//                    tvalid&~tready cycles while busy
//
// Optional build macro: CONV_SEQ_STATS_EN
//
// state  | meaning
// IDLE   | waiting for start
// SOF    | marker 123 at the head of the output queue
// STREAM | pixel beats of all bands
// EOF1   | waiting for acceptance of marker 124
// EOF2   | waiting for acceptance of marker 79
// DONE   | done pulse, back to IDLE next cycle
module conv_frame_sequencer #(
  parameter int IMG_W              = 64,
  parameter int IMG_H              = 64,
  parameter int ADDR_WIDTH         = 12,
  parameter int C_AXIS_TDATA_WIDTH = 32
) (
  input  logic                          m00_axis_aclk,
  input  logic                          m00_axis_areset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [7:0]                    mem_rdata,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                          m00_axis_tvalid,
  input  logic                          m00_axis_tready,
  output logic                          m00_axis_tlast
`ifdef CONV_SEQ_STATS_EN
  ,
  output logic [15:0]                   stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_STREAM, S_EOF1, S_EOF2, S_DONE
  } state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;

  localparam int COL_W  = $clog2(IMG_W);
  localparam int BAND_W = $clog2(IMG_H);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP2 = ADDR_WIDTH'(2 * IMG_W);
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [BAND_W-1:0]     BAND_LAST = BAND_W'(IMG_H - 3);

  state_t state, state_n;

  // Output register plus 2-entry skid buffer as one 3-deep queue; q[0] drives the stream.
  entry_t q [3];
  entry_t q_n [3];
  logic [1:0] cnt, cnt_n;

  logic pop, push, rd_go, room, mark1, mark2, accept_start, start_ok;
  entry_t push_entry;

  logic inflight, inflight_last;
  logic reads_done, eof1_pushed, eof2_pushed;
  logic [ADDR_WIDTH-1:0] row_base, off_ofs;
  logic [COL_W-1:0]      col;
  logic [1:0]            off;
  logic [BAND_W-1:0]     band_rd, band_out;
  logic                  read_last;

  assign start_ok  = start && !m00_axis_areset;
  assign pop       = (cnt != 2'd0) && m00_axis_tready;
  // A read is safe when the queue can still hold it after any pending return and this cycle's pop.
  assign room      = ({1'b0, cnt} + {2'b0, inflight}) < (3'd3 + {2'b0, pop});
  assign read_last = (off == 2'd2) && (col == COL_LAST);

  always_comb begin
    case (off)
      2'd0:    off_ofs = '0;
      2'd1:    off_ofs = ROW_STEP;
      default: off_ofs = ROW_STEP2;
    endcase
  end

  assign mem_addr = row_base + off_ofs + ADDR_WIDTH'(col);
  assign mem_en   = rd_go;

  always_comb begin
    state_n      = state;
    rd_go        = 1'b0;
    push         = 1'b0;
    push_entry   = '0;
    mark1        = 1'b0;
    mark2        = 1'b0;
    accept_start = 1'b0;

    // Markers 124/79 enter the queue only once every pixel read has returned.
    if (inflight) begin
      push       = 1'b1;
      push_entry = '{last: inflight_last, data: mem_rdata};
    end else if (state != S_IDLE && state != S_DONE && reads_done &&
                 (cnt != 2'd3 || pop)) begin
      if (!eof1_pushed) begin
        push       = 1'b1;
        push_entry = '{last: 1'b0, data: 8'd124};
        mark1      = 1'b1;
      end else if (!eof2_pushed) begin
        push       = 1'b1;
        push_entry = '{last: 1'b0, data: 8'd79};
        mark2      = 1'b1;
      end
    end

    case (state)
      S_IDLE: if (start_ok) begin
        state_n      = S_SOF;
        accept_start = 1'b1;
        rd_go        = 1'b1;  // prefetch pixel 0 alongside the marker
        push         = 1'b1;
        push_entry   = '{last: 1'b0, data: 8'd123};
      end
      S_SOF: begin
        rd_go = !reads_done && room;
        if (pop) state_n = S_STREAM;
      end
      S_STREAM: begin
        rd_go = !reads_done && room;
        if (pop && q[0].last && band_out == BAND_LAST) state_n = S_EOF1;
      end
      S_EOF1:  if (pop) state_n = S_EOF2;
      S_EOF2:  if (pop) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    q_n   = q;
    cnt_n = cnt;
    if (pop) begin
      q_n[0] = q[1];
      q_n[1] = q[2];
      cnt_n  = cnt - 2'd1;
    end
    if (push) begin
      for (int i = 0; i < 3; i++) begin
        if (cnt_n == 2'(i)) q_n[i] = push_entry;
      end
      cnt_n = cnt_n + 2'd1;
    end
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      for (int i = 0; i < 3; i++) q[i] <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      reads_done    <= 1'b0;
      eof1_pushed   <= 1'b0;
      eof2_pushed   <= 1'b0;
      row_base      <= '0;
      col           <= '0;
      off           <= '0;
      band_rd       <= '0;
      band_out      <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      for (int i = 0; i < 3; i++) q[i] <= q_n[i];
      inflight      <= rd_go;
      inflight_last <= read_last;
      if (accept_start) begin
        reads_done  <= 1'b0;
        eof1_pushed <= 1'b0;
        eof2_pushed <= 1'b0;
        band_out    <= '0;
      end
      if (mark1) eof1_pushed <= 1'b1;
      if (mark2) eof2_pushed <= 1'b1;
      if (pop && q[0].last) band_out <= band_out + 1'b1;
      // Counters return to zero after the final read, so IDLE always starts at address 0.
      if (rd_go) begin
        if (off != 2'd2) begin
          off <= off + 2'd1;
        end else begin
          off <= '0;
          if (col != COL_LAST) begin
            col <= col + 1'b1;
          end else begin
            col <= '0;
            if (band_rd != BAND_LAST) begin
              band_rd  <= band_rd + 1'b1;
              row_base <= row_base + ROW_STEP;
            end else begin
              band_rd    <= '0;
              row_base   <= '0;
              reads_done <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign m00_axis_tvalid = (cnt != 2'd0);
  assign m00_axis_tdata  = C_AXIS_TDATA_WIDTH'(q[0].data);
  assign m00_axis_tlast  = m00_axis_tvalid && q[0].last;

`ifdef CONV_SEQ_STATS_EN
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      stall_cycles <= '0;
    end else if (accept_start) begin
      stall_cycles <= '0;
    end else if (busy && m00_axis_tvalid && !m00_axis_tready &&
                 stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
